// File: rtl/bydin_pkg.sv
// Shared definitions for the bydin read sequencer: FSM state encoding and default sizing.
package bydin_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_INT = 2'd1,
    READ     = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  localparam logic [16:0] FRAME_LEN_DEF  = 17'd64512;
  localparam logic [2:0]  RD_LAT_DEF     = 3'd4;
  localparam logic [6:0]  FIFO_DEPTH_DEF = 7'd32;

endpackage

// File: rtl/bydin_credit.sv
// Tracks reads in flight between the memory and the FIFO and decides whether one more
// read may be issued without the downstream FIFO overflowing.
module bydin_credit
  import bydin_pkg::*;
#(
  parameter logic [6:0] FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       issue,
  input  logic       retire,
  input  logic [5:0] fifo_level,
  output logic [3:0] inflight,
  output logic       can_issue
);

  logic [6:0] credit_sum;

  // A retire with nothing in flight is a stray return; the count floors at zero.
  function automatic logic [3:0] next_inflight(input logic [3:0] cur, input logic inc,
                                               input logic dec);
    if (inc && !dec) return cur + 4'd1;
    if (dec && !inc) return (cur == 4'd0) ? 4'd0 : cur - 4'd1;
    return cur;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  inflight <= 4'd0;
    else if (clr)  inflight <= 4'd0;
    else           inflight <= next_inflight(inflight, issue, retire);
  end

  // The read issued this cycle is not yet in inflight, so it is charged explicitly.
  assign credit_sum = {1'b0, fifo_level} + {3'b000, inflight} + {6'b000000, issue};
  assign can_issue  = credit_sum < FIFO_DEPTH;

endmodule

// File: rtl/bydin_rd_ctrl.sv
// Frame read sequencer: arms on the frame interrupt and streams FRAME_LEN bytes to the FIFO
// under credit flow control. Optional XOR frame checksum enabled by macro BYDIN_SUM_EN.
module bydin_rd_ctrl
  import bydin_pkg::*;
#(
  parameter logic [16:0] FRAME_LEN  = FRAME_LEN_DEF,
  parameter logic [2:0]  RD_LAT     = RD_LAT_DEF,
  parameter logic [6:0]  FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ctrl_en,
  input  logic       bydin_int,
  output logic       mem_rd_ena,
  input  logic       mem_ena_out,
  input  logic [7:0] mem_data_out,
  input  logic [5:0] fifo_level,
  output logic       fifo_wr,
  output logic [7:0] fifo_wdata,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       ovr_err,
  input  logic       err_clr,
  output logic [7:0] frame_sum
);

  state_t      state;
  logic        int_d1;
  logic        int_edge;
  logic        start;
  logic        aborted;
  logic [16:0] issued_cnt;
  logic [17:0] issued_next;
  logic        last_issue;
  logic        issue_ok;
  logic        drain_done;
  logic [3:0]  inflight;
  logic        can_issue;

  assign int_edge   = bydin_int & ~int_d1;
  assign start      = (state == WAIT_INT) && ctrl_en && int_edge;
  assign frame_busy = (state == READ) || (state == DRAIN);

  // mem_rd_ena is registered, so the request already on the wire counts toward the frame.
  assign issued_next = {1'b0, issued_cnt} + {17'd0, mem_rd_ena};
  assign last_issue  = mem_rd_ena && (issued_cnt == FRAME_LEN - 17'd1);
  assign issue_ok    = (state == READ) && ctrl_en && can_issue &&
                       (issued_next < {1'b0, FRAME_LEN});
  assign drain_done  = (inflight == 4'd0) && !mem_rd_ena && !mem_ena_out && !fifo_wr;

  bydin_credit #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_credit (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (start),
    .issue      (mem_rd_ena),
    .retire     (fifo_wr),
    .fifo_level (fifo_level),
    .inflight   (inflight),
    .can_issue  (can_issue)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      int_d1     <= 1'b0;
      aborted    <= 1'b0;
      issued_cnt <= 17'd0;
      mem_rd_ena <= 1'b0;
      fifo_wr    <= 1'b0;
      fifo_wdata <= 8'h00;
      frame_done <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      int_d1     <= bydin_int;
      mem_rd_ena <= issue_ok;
      fifo_wr    <= mem_ena_out;
      fifo_wdata <= mem_data_out;
      frame_done <= 1'b0;

      // A new frame edge while busy is only flagged; setting beats a simultaneous clear.
      if (int_edge && frame_busy) ovr_err <= 1'b1;
      else if (err_clr)           ovr_err <= 1'b0;

      if (mem_rd_ena) issued_cnt <= issued_cnt + 17'd1;

      case (state)
        IDLE: begin
          if (ctrl_en) state <= WAIT_INT;
        end
        WAIT_INT: begin
          if (start) begin
            state      <= READ;
            issued_cnt <= 17'd0;
            aborted    <= 1'b0;
          end else if (!ctrl_en) begin
            state <= IDLE;
          end
        end
        READ: begin
          if (!ctrl_en) begin
            state   <= DRAIN;
            aborted <= 1'b1;
          end else if (last_issue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            frame_done <= !aborted;
            state      <= ctrl_en ? WAIT_INT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BYDIN_SUM_EN
  logic [7:0] sum_acc;

  // Accumulation is confined to the frame so the result holds after frame_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       sum_acc <= 8'h00;
    else if (start)                     sum_acc <= 8'h00;
    else if (mem_ena_out && frame_busy) sum_acc <= sum_acc ^ mem_data_out;
  end

  assign frame_sum = sum_acc;
`else
  assign frame_sum = 8'h00;
`endif

  a_stray_return: assert property (@(posedge clk) disable iff (!reset_n)
    mem_ena_out |-> ((inflight != 4'd0) && frame_busy))
    else $warning("bydin_rd_ctrl: read data returned with no read in flight");

  a_inflight_max: assert property (@(posedge clk) disable iff (!reset_n)
    inflight <= ({1'b0, RD_LAT} + 4'd1))
    else $error("bydin_rd_ctrl: inflight exceeds read latency bound");

endmodule

// File: tb/tb_bydin_rd_ctrl.sv
// Directed bench for bydin_rd_ctrl with a 4+1 cycle memory model and a small return monitor.
module tb_bydin_rd_ctrl;
  import bydin_pkg::*;

  localparam logic [16:0] FL = 17'd8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ctrl_en;
  logic       bydin_int;
  logic       mem_rd_ena;
  logic       mem_ena_out = 1'b0;
  logic [7:0] mem_data_out = 8'h00;
  logic [5:0] fifo_level;
  logic       fifo_wr;
  logic [7:0] fifo_wdata;
  logic       frame_busy;
  logic       frame_done;
  logic       ovr_err;
  logic       err_clr;
  logic [7:0] frame_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int int_cyc = 0;

  logic [4:0] vp = 5'd0;
  logic [7:0] dp [5];
  logic [7:0] data_tab [8];
  int rd_idx = 0;
  int n_iss = 0, n_wr = 0, n_done = 0, max_out = 0;
  int first_iss = 0, last_iss = 0;
  logic [7:0] sum_at_done = 8'h00;
  logic lat_en = 1'b0;
  int exp_cyc [$];
  logic [7:0] exp_dat [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bydin_rd_ctrl #(.FRAME_LEN(FL)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ctrl_en      (ctrl_en),
    .bydin_int    (bydin_int),
    .mem_rd_ena   (mem_rd_ena),
    .mem_ena_out  (mem_ena_out),
    .mem_data_out (mem_data_out),
    .fifo_level   (fifo_level),
    .fifo_wr      (fifo_wr),
    .fifo_wdata   (fifo_wdata),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .ovr_err      (ovr_err),
    .err_clr      (err_clr),
    .frame_sum    (frame_sum)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model and return monitor: shifts on the falling edge, away from the DUT's edge.
  always @(negedge clk) begin
    for (int i = 4; i > 0; i--) begin
      vp[i] = vp[i-1];
      dp[i] = dp[i-1];
    end
    vp[0] = mem_rd_ena;
    dp[0] = data_tab[rd_idx[2:0]];
    mem_ena_out  = vp[4];
    mem_data_out = dp[4];
    if (mem_rd_ena) begin
      if (n_iss == 0) first_iss = cyc;
      last_iss = cyc;
      n_iss++;
      rd_idx++;
      if (lat_en) begin
        exp_cyc.push_back(cyc);
        exp_dat.push_back(dp[0]);
      end
    end
    if (fifo_wr) begin
      n_wr++;
      if (lat_en) begin
        if (exp_cyc.size() == 0) check("wr_orphan", exp_cyc.size(), 1);
        else begin
          check("wr_latency", cyc - exp_cyc[0], 5);
          check("wr_data", int'(fifo_wdata), int'(exp_dat[0]));
          void'(exp_cyc.pop_front());
          void'(exp_dat.pop_front());
        end
      end
    end
    if (n_iss - n_wr > max_out) max_out = n_iss - n_wr;
    if (frame_done) begin
      n_done++;
      sum_at_done = frame_sum;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr_mon();
    n_iss = 0; n_wr = 0; n_done = 0; max_out = 0; rd_idx = 0;
    exp_cyc.delete();
    exp_dat.delete();
  endtask

  task automatic pulse_int();
    bydin_int = 1'b1;
    int_cyc   = cyc;
    step(1);
    bydin_int = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    int d0;
    d0 = n_done;
    while (n_done == d0 && k < 200) begin
      step(1);
      k++;
    end
    check(tag, n_done - d0, 1);
  endtask

  initial begin
    int cnt;
    int k;
    int mx;
    logic [7:0] exp_sum;
    for (int i = 0; i < 5; i++) dp[i] = 8'h00;
    for (int i = 0; i < 8; i++) data_tab[i] = 8'hA0 + 8'(i);
    reset_n = 1'b0; ctrl_en = 1'b0; bydin_int = 1'b0; err_clr = 1'b0; fifo_level = 6'd0;
    step(3);
    check("rst_rd_ena", mem_rd_ena, 0);
    check("rst_fifo_wr", fifo_wr, 0);
    check("rst_wdata", int'(fifo_wdata), 0);
    check("rst_busy", frame_busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovr", ovr_err, 0);
    check("rst_sum", int'(frame_sum), 0);

    // Basic frame of 8 bytes with no back-pressure.
    reset_n = 1'b1; ctrl_en = 1'b1;
    step(2);
    clr_mon(); lat_en = 1'b1;
    pulse_int();
    check("t1_busy", frame_busy, 1);
    wait_done("t1_done_seen");
    step(10);
    check("t1_issues", n_iss, 8);
    check("t1_first_lat", first_iss - int_cyc, 2);
    check("t1_b2b", last_iss - first_iss + 1, 8);
    check("t1_writes", n_wr, 8);
    check("t1_done_once", n_done, 1);
    check("t1_idle_busy", frame_busy, 0);

    // FIFO nearly full: level 30 of 32 leaves room for exactly two bytes in flight.
    clr_mon(); fifo_level = 6'd30;
    pulse_int();
    step(19);
    check("t2_stalled_issues", n_iss, 6);
    fifo_level = 6'd0;
    wait_done("t2_done_seen");
    check("t2_max_outstanding", max_out, 2);
    check("t2_issues", n_iss, 8);
    check("t2_writes", n_wr, 8);

    // Abort after three issues.
    step(2);
    clr_mon();
    pulse_int();
    cnt = 0; k = 0;
    while (cnt < 3 && k < 30) begin
      step(1);
      k++;
      if (mem_rd_ena) cnt++;
    end
    ctrl_en = 1'b0;
    step(20);
    check("t3_issues", n_iss, 3);
    check("t3_writes", n_wr, 3);
    check("t3_no_done", n_done, 0);
    check("t3_state_idle", int'(dut.state), int'(IDLE));
    pulse_int();
    step(5);
    check("t3_idle_ignores_int", n_iss, 3);
    ctrl_en = 1'b1;
    step(2);

    // Overrun: second edge during READ, then clear-versus-set priority.
    clr_mon();
    pulse_int();
    step(3);
    pulse_int();
    check("t4_ovr_set", ovr_err, 1);
    wait_done("t4_done_seen");
    step(2);
    check("t4_ovr_sticky", ovr_err, 1);
    check("t4_issues", n_iss, 8);
    clr_mon();
    pulse_int();
    step(3);
    bydin_int = 1'b1; err_clr = 1'b1;
    step(1);
    bydin_int = 1'b0; err_clr = 1'b0;
    check("t4_set_wins", ovr_err, 1);
    wait_done("t4b_done_seen");
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_cleared", ovr_err, 0);

    // Reset in the middle of READ; the two reads already in memory return afterwards.
    step(2);
    clr_mon(); lat_en = 1'b0;
    pulse_int();
    step(3);
    check("t5_pre_rd_ena", mem_rd_ena, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_rd_ena", mem_rd_ena, 0);
    check("t5_rst_busy", frame_busy, 0);
    check("t5_rst_wdata", int'(fifo_wdata), 0);
    step(1);
    reset_n = 1'b1;
    mx = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (int'(dut.u_credit.inflight) > mx) mx = int'(dut.u_credit.inflight);
    end
    check("t5_late_wr", n_wr, 2);
    check("t5_inflight_zero", mx, 0);
    check("t5_rearm", int'(dut.state), int'(WAIT_INT));
    check("t5_busy", frame_busy, 0);

    // Checksum frame: 01 ^ 02 ^ 04 ^ 80 followed by zero bytes.
    data_tab[0] = 8'h01; data_tab[1] = 8'h02; data_tab[2] = 8'h04; data_tab[3] = 8'h80;
    for (int i = 4; i < 8; i++) data_tab[i] = 8'h00;
`ifdef BYDIN_SUM_EN
    exp_sum = 8'h87;
`else
    exp_sum = 8'h00;
`endif
    clr_mon(); lat_en = 1'b1;
    pulse_int();
    wait_done("t6_done_seen");
    check("t6_sum_at_done", int'(sum_at_done), int'(exp_sum));
    step(5);
    check("t6_sum_hold", int'(frame_sum), int'(exp_sum));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
